// File: rtl/alu_rf_pipe.sv
// rtl/alu_rf_pipe.sv - two-stage ALU with register file, write bypass and PSR flags
module alu_rf_pipe #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    src,
  input  logic [WIDTH-1:0] immd,
  input  logic             use_immd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    result_dst,
  output logic [4:0]       flags,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_ASHU = 4'd8;

  // Shift magnitudes at or beyond this saturate
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);
  localparam logic [WIDTH:0] ONE_W1    = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_rf [NREGS];

  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [AW-1:0]    r_s1_dst;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [AW-1:0]    r_result_dst;
  logic [4:0]       r_flags;

  logic                    w_advance;
  logic                    w_wr_en;
  logic [WIDTH-1:0]        w_alu;
  logic [4:0]              w_flags_next;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_diff;
  logic                    w_add_ovf;
  logic                    w_sub_ovf;
  logic                    w_shneg;
  logic [WIDTH:0]          w_shamt;
  logic                    w_shsat;
  logic [WIDTH-1:0]        w_shl;
  logic [WIDTH-1:0]        w_shr;
  logic signed [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0]        w_lsh;
  logic [WIDTH-1:0]        w_ashu;
  logic [WIDTH-1:0]        w_opa;
  logic [WIDTH-1:0]        w_opb;

  // Both stages move together; a held result freezes the whole pipe
  assign w_advance  = !r_out_valid || out_ready;
  assign in_ready   = w_advance;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign result_dst = r_result_dst;
  assign flags      = r_flags;
  assign dbg_data   = r_rf[dbg_addr];

  // Stage-2 datapath: adder/subtractor, signed-count shifter, result mux and flags
  always_comb begin
    w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    w_diff    = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);

    // One extra bit so the magnitude of the most negative count is representable
    w_shneg = r_s1_b[WIDTH-1];
    w_shamt = w_shneg ? ({1'b0, ~r_s1_b} + ONE_W1) : {1'b0, r_s1_b};
    w_shsat = (w_shamt >= SHIFT_LIM);
    w_shl   = r_s1_a << w_shamt;
    w_shr   = r_s1_a >> w_shamt;
    w_asr   = $signed(r_s1_a) >>> w_shamt;
    w_lsh   = w_shsat ? '0 : (w_shneg ? w_shr : w_shl);
    if (w_shsat) begin
      w_ashu = w_shneg ? {WIDTH{r_s1_a[WIDTH-1]}} : '0;
    end else begin
      w_ashu = w_shneg ? $unsigned(w_asr) : w_shl;
    end

    case (r_s1_op)
      OP_ADD:         w_alu = w_sum[WIDTH-1:0];
      OP_AND:         w_alu = r_s1_a & r_s1_b;
      OP_OR:          w_alu = r_s1_a | r_s1_b;
      OP_XOR:         w_alu = r_s1_a ^ r_s1_b;
      OP_SUB, OP_CMP: w_alu = w_diff[WIDTH-1:0];
      OP_MOV:         w_alu = r_s1_b;
      OP_LSH:         w_alu = w_lsh;
      OP_ASHU:        w_alu = w_ashu;
      default:        w_alu = '0;
    endcase

    // PSR layout {N,Z,F,L,C}
    w_flags_next = r_flags;
    if (r_s1_op == OP_ADD) begin
      w_flags_next = {1'b0, (w_sum[WIDTH-1:0] == '0), w_add_ovf, 1'b0, w_sum[WIDTH]};
    end else if (r_s1_op == OP_SUB || r_s1_op == OP_CMP) begin
      w_flags_next = {w_diff[WIDTH-1] ^ w_sub_ovf, (r_s1_a == r_s1_b), w_sub_ovf,
                      w_diff[WIDTH], w_diff[WIDTH]};
    end

    w_wr_en = r_s1_valid && w_advance && (r_s1_op <= OP_ASHU) && (r_s1_op != OP_CMP);
  end

  // Stage-1 operand fetch, forwarding the value being written at this same edge
  always_comb begin
    w_opa = r_rf[dst];
    if (w_wr_en && (r_s1_dst == dst)) w_opa = w_alu;
    w_opb = use_immd ? immd : r_rf[src];
    if (!use_immd && w_wr_en && (r_s1_dst == src)) w_opb = w_alu;
  end

  // Pipeline, register file and PSR update; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_op      <= '0;
      r_s1_dst     <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_result_dst <= '0;
      r_flags      <= '0;
    end else if (w_advance) begin
      if (w_wr_en) r_rf[r_s1_dst] <= w_alu;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_flags      <= w_flags_next;
        r_result     <= w_alu;
        r_result_dst <= r_s1_dst;
      end
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= op;
        r_s1_dst <= dst;
        r_s1_a   <= w_opa;
        r_s1_b   <= w_opb;
      end
    end
  end

endmodule

// File: tb/tb_alu_rf_pipe.sv
// tb/tb_alu_rf_pipe.sv - directed and random checks of alu_rf_pipe against a sequential reference model
module tb_alu_rf_pipe;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [AW-1:0] dst;
  logic [AW-1:0] src;
  logic [W-1:0]  immd;
  logic          use_immd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [AW-1:0] result_dst;
  logic [4:0]    flags;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  alu_rf_pipe #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src(src), .immd(immd), .use_immd(use_immd),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_dst(result_dst), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int dst;
    int fl;
  } ret_t;

  ret_t exp_q[$];
  int   mrf[N];
  int   mflags;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Architectural (one op at a time) semantics; flags bits: C=1 L=2 F=4 Z=8 N=16
  task automatic model_exec(input int o, input int d, input int s, input int imm, input bit ui);
    int a, b, r, sa, sb, cnt;
    bit wr;
    ret_t e;
    a = mrf[d];
    b = ui ? imm : mrf[s];
    sa = sx(a);
    sb = sx(b);
    cnt = sb;
    wr = 1'b1;
    r = 0;
    case (o)
      0: begin
        r = (a + b) % 65536;
        mflags = ((a + b >= 65536) ? 1 : 0) | ((sa + sb > 32767 || sa + sb < -32768) ? 4 : 0)
               | ((r == 0) ? 8 : 0);
      end
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4, 5: begin
        r = (a - b + 65536) % 65536;
        mflags = ((a < b) ? 3 : 0) | ((sa - sb > 32767 || sa - sb < -32768) ? 4 : 0)
               | ((a == b) ? 8 : 0) | ((sa < sb) ? 16 : 0);
        wr = (o == 4);
      end
      6: r = b;
      7: begin
        if (cnt >= 16 || cnt <= -16) r = 0;
        else if (cnt >= 0) r = (a << cnt) % 65536;
        else r = a >> (-cnt);
      end
      8: begin
        if (cnt >= 16) r = 0;
        else if (cnt >= 0) r = (a << cnt) % 65536;
        else if (cnt <= -16) r = (sa < 0) ? 65535 : 0;
        else r = (sa >>> (-cnt)) & 65535;
      end
      default: begin
        r = 0;
        wr = 1'b0;
      end
    endcase
    if (wr) mrf[d] = r;
    e.res = r;
    e.dst = d;
    e.fl  = mflags;
    exp_q.push_back(e);
  endtask

  // One clock: score presented result, model an accepted issue, advance to next negedge
  task automatic tick();
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("result", 32'(result), exp_q[0].res);
        chk("result_dst", 32'(result_dst), exp_q[0].dst);
        chk("flags", 32'(flags), exp_q[0].fl);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready)
      model_exec(int'(op), int'(dst), int'(src), int'(immd), use_immd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int o, input int d, input int s, input int imm, input bit ui);
    in_valid = 1'b1;
    op       = 4'(o);
    dst      = AW'(d);
    src      = AW'(s);
    immd     = W'(imm);
    use_immd = ui;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_reg(input string tag, input int r, input int exp);
    dbg_addr = AW'(r);
    #1;
    chk(tag, 32'(dbg_data), exp);
  endtask

  // Only used with the pipe empty, so skipped edges change nothing
  task automatic dbg_all(input string tag);
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk(tag, 32'(dbg_data), mrf[i]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) mrf[i] = 0;
    mflags = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; op = '0; dst = '0; src = '0; immd = '0; use_immd = 1'b0;
    out_ready = 1'b1; dbg_addr = '0; reset = 1'b0;
    for (int i = 0; i < N; i++) mrf[i] = 0;
    mflags = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_dst", 32'(result_dst), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    dbg_all("rst_rf");

    // ADD r1,#1: result visible two edges after it is presented
    issue(0, 1, 0, 1, 1);
    in_valid = 1'b0;
    #1;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", 32'(result), 32'd1);
    chk_reg("lat_rf1", 1, 1);
    tick();

    // Dependent back-to-back ops through the bypass
    issue(0, 2, 0, 15, 1);
    #1;
    chk("b2b_no_stall", 32'(in_ready), 32'd1);
    issue(0, 2, 1, 0, 0);
    idle();
    idle();
    chk_reg("b2b_rf2", 2, 16);

    // SUB r1,r1 then CMP r2,#20
    issue(4, 1, 1, 0, 0);
    issue(5, 2, 0, 20, 1);
    idle();
    idle();
    chk("cmp_flags", 32'(flags), 32'b10011);
    chk_reg("cmp_no_write", 2, 16);

    // Shifts, each reloading r2
    issue(6, 2, 0, 16, 1);
    issue(7, 2, 0, -1, 1);
    issue(6, 2, 0, 16, 1);
    issue(7, 2, 0, 1, 1);
    issue(6, 2, 0, 'h8000, 1);
    issue(8, 2, 0, -2, 1);
    idle();
    idle();
    chk_reg("ashu_rf2", 2, 'he000);
    issue(6, 2, 0, 16, 1);
    issue(7, 2, 0, 16, 1);
    issue(6, 3, 0, 'h8000, 1);
    issue(8, 3, 0, -20, 1);
    idle();
    idle();
    chk_reg("lsh_sat", 2, 0);
    chk_reg("ashu_sat", 3, 'hffff);

    // Stall with two ops in flight; increments expose any repeated write
    issue(6, 3, 0, 0, 1);
    issue(0, 3, 0, 1, 1);
    issue(0, 3, 0, 2, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 4'd0; dst = AW'(3); immd = W'(100); use_immd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk_reg("stall_rf3", 3, 1);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) tick();
    chk_reg("stall_rf3_after", 3, 3);

    // Random traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      op        = 4'($urandom_range(0, 15));
      dst       = AW'($urandom_range(0, N - 1));
      src       = AW'($urandom_range(0, N - 1));
      immd      = ($urandom_range(0, 2) == 0) ? W'(int'($urandom_range(0, 40)) - 20) : W'($urandom);
      use_immd  = $urandom_range(0, 1) != 0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    dbg_all("rand_rf");

    // Reset with an op sitting in stage 1
    out_ready = 1'b1;
    issue(0, 5, 0, 7, 1);
    do_reset();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    dbg_all("midrst_rf");
    issue(0, 5, 0, 7, 1);
    idle();
    idle();
    chk_reg("post_rst_rf5", 5, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rf_pipe.md
ALU_RF_PIPE -- requirements
Module: alu_rf_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath and register width (SHALL support 8..32).
REQ-002 Parameter NREGS, default 16, register count, power of two; AW = clog2(NREGS).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset reset, synchronous, active-low.
REQ-005 in_valid  input  1  issue request.
REQ-006 in_ready  output  1  block accepts issue this cycle.
REQ-007 op  input  4  0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 CMP, 0110 MOV, 0111 LSH, 1000 ASHU; others are NOP.
REQ-008 dst  input  AW  destination register, also operand A.
REQ-009 src  input  AW  source register, operand B when use_immd=0.
REQ-010 immd  input  WIDTH  pre-extended immediate, operand B when use_immd=1.
REQ-011 use_immd  input  1  operand B select.
REQ-012 out_valid  output  1  result/flags of one retired op are presented.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  WIDTH  retired result.
REQ-015 result_dst  output  AW  retired destination.
REQ-016 flags  output  5  PSR {N,Z,F,L,C}, bit 0 = C.
REQ-017 dbg_addr  input  AW / dbg_data  output  WIDTH  combinational register-file read port.

Function
REQ-018 Accept: an issue is accepted on a rising edge with in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-019 Stage 1 (accept edge): latch op, dst, and operands A = RF[dst], B = use_immd ? immd : RF[src].
REQ-020 Stage 2 (next advancing edge): compute; write RF[dst] unless op is CMP or NOP; update flags; register result/result_dst; set out_valid.
REQ-021 Latency: out_valid SHALL be high exactly 2 edges after acceptance when out_ready stays high; throughput SHALL be 1 op/cycle.
REQ-022 Bypass: an operand read in stage 1 whose register equals the register being written at the same edge SHALL take the new value, so back-to-back dependent ops need no stall.
REQ-023 Stall: while out_valid && !out_ready, both stages, RF, and flags SHALL hold; no write is repeated.
REQ-024 Arithmetic is mod 2^WIDTH. ADD: A+B. SUB/CMP: A-B. AND/OR/XOR: bitwise. MOV: B.
REQ-025 LSH/ASHU: signed shift count from B; positive shifts left and negative shifts right. LSH fills with zeros; ASHU right-fills with A's sign bit.
REQ-026 Shift saturation: |count| >= WIDTH SHALL give 0 for LSH and for left ASHU, and all-sign-bits for right ASHU.
REQ-027 ADD flags: C = carry out, F = signed overflow, Z = (result==0), L = 0, N = 0.
REQ-028 SUB/CMP flags: C = L = (A<B unsigned), N = (A<B signed), Z = (A==B), F = signed overflow of A-B.
REQ-029 All other ops SHALL leave flags unchanged.
REQ-030 NOP SHALL retire with out_valid=1 and result=0, and SHALL NOT write the RF.
REQ-031 CMP SHALL retire with result = A-B, and SHALL NOT write the RF.

Reset
REQ-032 When reset=0 at an edge: all RF entries, flags, result, result_dst = 0; out_valid = 0; both stages empty.
REQ-033 Reset SHALL take priority over accept and writeback; an op in flight at reset SHALL be discarded with no RF write.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 After reset: issue ADD r1,#1 -> out_valid 2 edges later, result=1, RF[1]=1, flags=00000.
REQ-036 Back-to-back ADD r2,#15 then ADD r2,r1 on consecutive cycles -> results 15 then 16 via bypass; no stall cycle.
REQ-037 r1=1; SUB r1,r1 -> result 0, Z=1, C=L=N=F=0; then CMP r2(16),#20 -> C=L=N=1, Z=0, RF[2] still 16.
REQ-038 Shifts with r2=16 (WIDTH=16): LSH #-1 -> 8; LSH #1 -> 32; r2=0x8000 ASHU #-2 -> 0xE000; LSH #16 -> 0.
REQ-039 Hold out_ready=0 for 3 cycles with 2 ops in flight -> in_ready=0, result stable, each RF write occurs exactly once after release.
REQ-040 Assert reset with an op in stage 1 -> no RF write, out_valid=0, dbg_data(any)=0.
